// File: rtl/uart_frame_ctrl.sv
// Frame sequencer between a byte UART and an arithmetic core: packs RX bytes into an
// operand, starts the core, then streams the core's result back out MSB first.
module uart_frame_ctrl #(
  parameter int NBYTES_IN   = 4,
  parameter int NBYTES_OUT  = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RX_DONE,
  input  logic [7:0]              RX_DATA,
  input  logic                    TX_DONE,
  output logic                    TX_START,
  output logic [7:0]              TX_DATA,
  output logic [8*NBYTES_IN-1:0]  OP_DATA,
  output logic                    OP_START,
  input  logic [8*NBYTES_OUT-1:0] RES_DATA,
  input  logic                    RES_DONE,
  output logic                    BUSY,
  output logic                    ERR_TO,
  output logic                    ERR_OVR,
  output logic [2:0]              dbg_state
);

  localparam int W_IN  = 8 * NBYTES_IN;
  localparam int W_OUT = 8 * NBYTES_OUT;
  localparam int RXW   = $clog2(NBYTES_IN + 1);
  localparam int TXW   = $clog2(NBYTES_OUT + 1);
  localparam int TOW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [RXW-1:0] RX_ONE  = RXW'(1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(NBYTES_IN - 1);
  localparam logic [TXW-1:0] TX_ONE  = TXW'(1);
  localparam logic [TXW-1:0] TX_FULL = TXW'(NBYTES_OUT);
  localparam logic [TOW-1:0] TO_ONE  = TOW'(1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    START_OP = 3'd2,
    WAIT_OP  = 3'd3,
    SEND     = 3'd4,
    WAIT_TX  = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [RXW-1:0]   rx_cnt, rx_cnt_d;
  logic [TXW-1:0]   tx_cnt, tx_cnt_d;
  logic [TOW-1:0]   to_cnt, to_cnt_d;
  logic [W_OUT-1:0] tx_shift, tx_shift_d;
  logic [W_IN-1:0]  op_data, op_data_d;
  logic [7:0]       tx_data, tx_data_d;
  logic             tx_start, tx_start_d;
  logic             op_start, op_start_d;
  logic             busy, busy_d;
  logic             err_to, err_to_d;
  logic             err_ovr, err_ovr_d;

  logic [W_IN+7:0]  op_cat;
  logic [W_OUT+7:0] tx_cat;

  assign op_cat = {op_data, RX_DATA};
  assign tx_cat = {tx_shift, 8'h00};

  // Handshake: RX_DONE/RES_DONE/TX_DONE are single-cycle strobes that are always
  // consumed in the cycle they arrive (no backpressure); OP_START and TX_START are
  // single-cycle strobes one cycle after their triggering event.
  always_comb begin
    state_d    = state;
    rx_cnt_d   = rx_cnt;
    tx_cnt_d   = tx_cnt;
    to_cnt_d   = '0;
    tx_shift_d = tx_shift;
    op_data_d  = op_data;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    op_start_d = 1'b0;
    err_to_d   = 1'b0;
    err_ovr_d  = 1'b0;

    case (state)
      IDLE, RECV: begin
        if (RX_DONE) begin
          op_data_d = op_cat[W_IN-1:0];
          if (rx_cnt == RX_LAST) begin
            rx_cnt_d   = '0;
            state_d    = START_OP;
            op_start_d = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt + RX_ONE;
            state_d  = RECV;
          end
        end else if (state == RECV) begin
          // A byte arriving on the last allowed cycle takes the branch above instead.
          if (to_cnt == TO_LAST) begin
            state_d  = IDLE;
            rx_cnt_d = '0;
            err_to_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt + TO_ONE;
          end
        end
      end
      START_OP: begin
        err_ovr_d = RX_DONE;
        state_d   = WAIT_OP;
      end
      WAIT_OP: begin
        err_ovr_d = RX_DONE;
        if (RES_DONE) begin
          tx_shift_d = RES_DATA;
          tx_data_d  = RES_DATA[W_OUT-1 -: 8];
          tx_cnt_d   = TX_FULL;
          tx_start_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        err_ovr_d = RX_DONE;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        err_ovr_d = RX_DONE;
        if (TX_DONE) begin
          tx_shift_d = tx_cat[W_OUT-1:0];
          tx_cnt_d   = tx_cnt - TX_ONE;
          if (tx_cnt == TX_ONE) begin
            state_d = IDLE;
          end else begin
            tx_data_d  = tx_cat[W_OUT-1 -: 8];
            tx_start_d = 1'b1;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      to_cnt   <= '0;
      tx_shift <= '0;
      op_data  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      op_start <= 1'b0;
      busy     <= 1'b0;
      err_to   <= 1'b0;
      err_ovr  <= 1'b0;
    end else begin
      state    <= state_d;
      rx_cnt   <= rx_cnt_d;
      tx_cnt   <= tx_cnt_d;
      to_cnt   <= to_cnt_d;
      tx_shift <= tx_shift_d;
      op_data  <= op_data_d;
      tx_data  <= tx_data_d;
      tx_start <= tx_start_d;
      op_start <= op_start_d;
      busy     <= busy_d;
      err_to   <= err_to_d;
      err_ovr  <= err_ovr_d;
    end
  end

  assign TX_START  = tx_start;
  assign TX_DATA   = tx_data;
  assign OP_DATA   = op_data;
  assign OP_START  = op_start;
  assign BUSY      = busy;
  assign ERR_TO    = err_to;
  assign ERR_OVR   = err_ovr;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: frame capture, result streaming, timeout,
// overrun, mid-transmit reset and ignored strobes, with a TX byte scoreboard.
module tb_uart_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] op_data;
  logic        op_start;
  logic [31:0] res_data = 32'h0;
  logic        res_done = 1'b0;
  logic        busy;
  logic        err_to;
  logic        err_ovr;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int tx_start_cnt = 0;
  int op_start_cnt = 0;
  int err_to_cnt   = 0;
  int err_ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_frame_ctrl #(
    .NBYTES_IN  (4),
    .NBYTES_OUT (4),
    .TIMEOUT_CYC(50)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX_DONE  (rx_done),
    .RX_DATA  (rx_data),
    .TX_DONE  (tx_done),
    .TX_START (tx_start),
    .TX_DATA  (tx_data),
    .OP_DATA  (op_data),
    .OP_START (op_start),
    .RES_DATA (res_data),
    .RES_DONE (res_done),
    .BUSY     (busy),
    .ERR_TO   (err_to),
    .ERR_OVR  (err_ovr),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every transmitted byte must match the head of exp_q
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_start_cnt++;
      if (exp_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
    if (op_start === 1'b1) op_start_cnt++;
    if (err_to === 1'b1) err_to_cnt++;
    if (err_ovr === 1'b1) err_ovr_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      rx_byte(w[8*i +: 8]);
      if (i != 0) begin
        tick();
        tick();
      end
    end
  endtask

  task automatic give_result(input logic [31:0] r);
    res_data = r;
    res_done = 1'b1;
    tick();
    res_done = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] r);
    for (int i = 3; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
  endtask

  task automatic serve_tx(input int n, input int dly);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      while (tx_start !== 1'b1 && k < 100) begin
        tick();
        k++;
      end
      check("tx_start_seen", {31'h0, tx_start}, 32'd1);
      check("tx_start_lat", k, 0);
      repeat (dly) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"}, {31'h0, tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'd0);
    check({tag, "_op_data"}, op_data, 32'd0);
    check({tag, "_op_start"}, {31'h0, op_start}, 32'd0);
    check({tag, "_busy"}, {31'h0, busy}, 32'd0);
    check({tag, "_err_to"}, {31'h0, err_to}, 32'd0);
    check({tag, "_err_ovr"}, {31'h0, err_ovr}, 32'd0);
    check({tag, "_state"}, {29'h0, dbg_state}, 32'd0);
  endtask

  initial begin
    int op0;
    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // 1: operand capture and single OP_START
    send_frame(32'h3F80_0000);
    check("t1_op_start", {31'h0, op_start}, 32'd1);
    check("t1_op_data", op_data, 32'h3F80_0000);
    check("t1_busy", {31'h0, busy}, 32'd1);
    tick();
    check("t1_op_start_low", {31'h0, op_start}, 32'd0);
    check("t1_state_wait_op", {29'h0, dbg_state}, 32'd3);
    tick();

    // 2: result streaming
    push_exp(32'h1234_5678);
    give_result(32'h1234_5678);
    check("t2_first_tx_data", {24'h0, tx_data}, 32'h12);
    serve_tx(4, 20);
    check("t2_busy_done", {31'h0, busy}, 32'd0);
    check("t2_state_idle", {29'h0, dbg_state}, 32'd0);

    // 3: inter-byte timeout drops partial frame
    op0 = op_start_cnt;
    rx_byte(8'h01);
    tick();
    rx_byte(8'h02);
    repeat (49) tick();
    check("t3_no_to_yet", {31'h0, err_to}, 32'd0);
    check("t3_busy_before", {31'h0, busy}, 32'd1);
    tick();
    check("t3_err_to", {31'h0, err_to}, 32'd1);
    check("t3_busy_after", {31'h0, busy}, 32'd0);
    tick();
    check("t3_err_to_low", {31'h0, err_to}, 32'd0);
    check("t3_no_op_start", op_start_cnt, op0);
    // RX_DONE on the final allowed cycle is captured, not timed out
    rx_byte(8'hAA);
    tick();
    rx_byte(8'hBB);
    tick();
    rx_byte(8'hCC);
    repeat (49) tick();
    rx_byte(8'hDD);
    check("t3_op_data", op_data, 32'hAABB_CCDD);
    check("t3_op_start", {31'h0, op_start}, 32'd1);
    check("t3_err_to_cnt", err_to_cnt, 1);
    tick();

    // 4: overrun together with RES_DONE in WAIT_OP
    push_exp(32'hCAFE_F00D);
    rx_data  = 8'h55;
    rx_done  = 1'b1;
    give_result(32'hCAFE_F00D);
    rx_done  = 1'b0;
    check("t4_err_ovr", {31'h0, err_ovr}, 32'd1);
    check("t4_tx_data", {24'h0, tx_data}, 32'hCA);
    check("t4_op_data", op_data, 32'hAABB_CCDD);
    serve_tx(4, 3);
    check("t4_op_data_after", op_data, 32'hAABB_CCDD);
    check("t4_busy_done", {31'h0, busy}, 32'd0);

    // 5: reset during WAIT_TX aborts transmission
    send_frame(32'h0102_0304);
    tick();
    exp_q.push_back(8'h11);
    give_result(32'h1122_3344);
    tick();
    check("t5_state_wait_tx", {29'h0, dbg_state}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("t5_rst");
    repeat (10) tick();
    check("t5_idle_quiet", {31'h0, busy}, 32'd0);
    send_frame(32'h3F80_0000);
    check("t5_op_data", op_data, 32'h3F80_0000);
    tick();
    push_exp(32'h0BAD_BEEF);
    give_result(32'h0BAD_BEEF);
    serve_tx(4, 2);
    check("t5_busy_done", {31'h0, busy}, 32'd0);

    // 6: stray TX_DONE / RES_DONE in IDLE are ignored
    tx_done  = 1'b1;
    res_data = 32'h9999_9999;
    res_done = 1'b1;
    tick();
    tx_done  = 1'b0;
    res_done = 1'b0;
    tick();
    check("t6_state", {29'h0, dbg_state}, 32'd0);
    check("t6_busy", {31'h0, busy}, 32'd0);
    check("t6_tx_data", {24'h0, tx_data}, 32'hEF);
    check("t6_op_data", op_data, 32'h3F80_0000);
    repeat (3) tick();

    // final report
    check("tx_left", exp_q.size(), 0);
    check("tx_start_total", tx_start_cnt, 13);
    check("op_start_total", op_start_cnt, 4);
    check("err_to_total", err_to_cnt, 1);
    check("err_ovr_total", err_ovr_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
